// File: rtl/mem_ram_ctrl.sv
// Memory-stage RAM controller: turns a load/store request into a read
// (and, for stores, a read-modify-write) bus transaction with a wait timeout.
module mem_ram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ram_ce_i,
    input  logic                  ram_w_request_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_wdata_i,
    output logic [DATA_WIDTH-1:0] ram_rdata_o,
    output logic                  stall_req_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  bus_err_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    logic                  req;
    logic                  we;
    logic                  timeout;
    logic                  unused_addr_bits;

    // State, wait counter, read-data and bus-control registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
            req   <= 1'b0;
            we    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rdata <= rdata_nxt;
            req   <= (state_nxt == RD) || (state_nxt == WR);
            we    <= (state_nxt == WR);
        end
    end

    // Next-state, counter and read-data update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (ram_ce_i) begin
                    state_nxt = RD;
                    cnt_nxt   = '0;
                end
            end
            RD: begin
                if (bus_ack_i) begin
                    rdata_nxt = bus_rdata_i;
                    cnt_nxt   = '0;
                    state_nxt = ram_w_request_i ? WR : DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    rdata_nxt = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WR: begin
                if (bus_ack_i) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    rdata_nxt = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stall covers the request cycle in IDLE plus every bus phase
    assign stall_req_o = ~rst_i & (((state == IDLE) & ram_ce_i) | (state == RD) | (state == WR));

    assign ram_rdata_o = rdata;
    assign bus_req_o   = req;
    assign bus_we_o    = we;
    assign bus_err_o   = timeout;
    assign bus_addr_o  = {ram_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign bus_wdata_o = (state == WR) ? ram_wdata_i : '0;

    assign unused_addr_bits = ^ram_addr_i[1:0];

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// Scoreboard bench for mem_ram_ctrl: a wait-programmable bus model answers
// requests, expected per-transaction results are queued and checked at DONE.
module tb_mem_ram_ctrl;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        clk;
    logic        rst_i;
    logic        ram_ce_i;
    logic        ram_w_request_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_wdata_i;
    logic [31:0] ram_rdata_o;
    logic        stall_req_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    mem_ram_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .ram_ce_i        (ram_ce_i),
        .ram_w_request_i (ram_w_request_i),
        .ram_addr_i      (ram_addr_i),
        .ram_wdata_i     (ram_wdata_i),
        .ram_rdata_o     (ram_rdata_o),
        .stall_req_o     (stall_req_o),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_rdata_i     (bus_rdata_i),
        .bus_ack_i       (bus_ack_i),
        .bus_err_o       (bus_err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] hold;
        logic [31:0] rdata;
        logic [31:0] wdata;
        int          stall;
        int          wr_cycles;
        int          errs;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          rd_wait  = 0;
    int          wr_wait  = 0;
    logic [31:0] rd_val   = '0;
    logic        spurious = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Bus model: acks after rd_wait/wr_wait idle cycles of the current phase
    initial begin
        int   wcnt;
        logic prev_req;
        logic prev_we;
        wcnt = 0; prev_req = 1'b0; prev_we = 1'b0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req_o && prev_req && (bus_we_o == prev_we)) wcnt++;
            else wcnt = 0;
            prev_req = bus_req_o;
            prev_we  = bus_we_o;
            bus_ack_i = spurious || (bus_req_o && (wcnt == (bus_we_o ? wr_wait : rd_wait)));
            if (bus_ack_i) bus_rdata_i = (bus_req_o && !bus_we_o) ? rd_val : 32'hBAD0BAD0;
            else           bus_rdata_i = $urandom();
        end
    end

    // Monitor: per-cycle phase checks, scoreboard pop when the bus request ends
    initial begin
        int   stall_cnt;
        int   err_cnt;
        int   wr_cnt;
        logic prev_req;
        exp_t e;
        stall_cnt = 0; err_cnt = 0; wr_cnt = 0; prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                stall_cnt = 0; err_cnt = 0; wr_cnt = 0; prev_req = 1'b0;
            end else begin
                if (stall_req_o) stall_cnt++;
                if (bus_err_o) err_cnt++;
                if (bus_req_o && exp_q.size() > 0) begin
                    check("bus_addr", bus_addr_o, exp_q[0].addr);
                    if (bus_we_o) begin
                        wr_cnt++;
                        check("wr_wdata", bus_wdata_o, exp_q[0].wdata);
                        check("wr_rdata_hold", ram_rdata_o, exp_q[0].hold);
                    end
                end
                if (prev_req && !bus_req_o) begin
                    check("sb_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("done_stall_low", stall_req_o, 0);
                        check("done_rdata", ram_rdata_o, e.rdata);
                        check("stall_cycles", stall_cnt, e.stall);
                        check("err_pulses", err_cnt, e.errs);
                        check("wr_cycles", wr_cnt, e.wr_cycles);
                    end
                    done_cnt++;
                    stall_cnt = 0; err_cnt = 0; wr_cnt = 0;
                end
                prev_req = bus_req_o;
            end
        end
    end

    task automatic start_txn(input logic w, input logic [31:0] addr, input logic [31:0] rval,
                             input logic [31:0] merged, input int rw, input int ww);
        exp_t e;
        bit   rd_to;
        bit   wr_to;
        int   rd_cyc;
        int   wr_cyc;
        rd_to  = (rw >= TIMEOUT);
        rd_cyc = rd_to ? TIMEOUT : rw + 1;
        wr_to  = w && !rd_to && (ww >= TIMEOUT);
        wr_cyc = (w && !rd_to) ? (wr_to ? TIMEOUT : ww + 1) : 0;
        e.addr      = {addr[31:2], 2'b00};
        e.hold      = rval;
        e.rdata     = (rd_to || wr_to) ? 32'h0 : rval;
        e.wdata     = merged;
        e.stall     = 1 + rd_cyc + wr_cyc;
        e.wr_cycles = wr_cyc;
        e.errs      = (rd_to || wr_to) ? 1 : 0;
        exp_q.push_back(e);
        rd_wait = rw; wr_wait = ww; rd_val = rval;
        ram_ce_i = 1'b1; ram_w_request_i = w; ram_addr_i = addr; ram_wdata_i = merged;
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            spurious = 1'b0;
            if (done_cnt != start) break;
        end
        check("done_seen", done_cnt != start, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic w, input logic [31:0] addr, input logic [31:0] rval,
                       input logic [31:0] merged, input int rw, input int ww);
        start_txn(w, addr, rval, merged, rw, ww);
        wait_done();
    endtask

    task automatic idle(input int n);
        ram_ce_i = 1'b0; ram_w_request_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; ram_ce_i = 1'b0; ram_w_request_i = 1'b0;
        ram_addr_i = '0; ram_wdata_i = '0;
        @(negedge clk);
        check("rst_bus_req", bus_req_o, 0);
        check("rst_bus_we", bus_we_o, 0);
        check("rst_stall", stall_req_o, 0);
        check("rst_err", bus_err_o, 0);
        check("rst_rdata", ram_rdata_o, 0);
        check("rst_wdata", bus_wdata_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        idle(2);

        // zero-wait load, then RMW store
        txn(1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
        idle(2);
        txn(1'b1, 32'h201, 32'h11223344, 32'h1122AA44, 3, 0);
        idle(2);
        // read timeout and boundary ack
        txn(1'b0, 32'h40, 32'h12345678, 32'h0, NEVER, 0);
        idle(1);
        txn(1'b0, 32'h44, 32'hA5A55A5A, 32'h0, TIMEOUT - 1, 0);
        idle(1);
        // back-to-back with spurious ack in IDLE, ending in a write timeout
        txn(1'b0, 32'h10, 32'h01010101, 32'h0, 0, 0);
        spurious = 1'b1;
        txn(1'b0, 32'h14, 32'h02020202, 32'h0, 1, 0);
        txn(1'b1, 32'h18, 32'h03030303, 32'h0303FF03, 0, NEVER);
        idle(2);
        // ce dropped mid-read must not abort
        start_txn(1'b0, 32'h88, 32'h5555AAAA, 32'h0, 5, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ram_ce_i = 1'b0;
        wait_done();
        idle(1);
        // store whose read phase times out: no write phase
        txn(1'b1, 32'h9C, 32'h77777777, 32'h0, NEVER, 0);
        idle(1);

        // reset during a stalled write phase
        start_txn(1'b1, 32'h300, 32'hFEEDFACE, 32'h99999999, 0, NEVER);
        for (int i = 0; i < 50 && !bus_we_o; i++) begin
            @(negedge clk); #1;
        end
        check("reached_wr", bus_we_o, 1);
        @(posedge clk); #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_bus_req", bus_req_o, 0);
        check("rst_mid_bus_we", bus_we_o, 0);
        check("rst_mid_stall", stall_req_o, 0);
        check("rst_mid_rdata", ram_rdata_o, 0);
        check("rst_mid_wdata", bus_wdata_o, 0);
        check("rst_mid_err", bus_err_o, 0);
        exp_q.delete();
        start_txn(1'b0, 32'h304, 32'hCAFEF00D, 32'h0, 0, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        check("restart_rd_req", bus_req_o, 1);
        check("restart_rd_we", bus_we_o, 0);
        wait_done();
        idle(1);

        // short random mix
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            logic [31:0] v;
            logic [31:0] m;
            a = $urandom(); v = $urandom(); m = $urandom();
            txn(1'($urandom_range(0, 1)), a, v, m, $urandom_range(0, 4), $urandom_range(0, 4));
            idle($urandom_range(0, 2));
        end

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
